// File: rtl/pwm_tick_gen_mc.sv
// pwm_tick_gen_mc: multi-channel programmable tick generator that paces PWM counters.
// Each channel divides clk by (div_act+1) and emits a registered one-cycle tick.
// Divisor writes land in a shadow register. The shadow is moved into the active
// divisor only at a period boundary, when the channel is disabled, or on a global
// sync, so a running period is never cut short.

// Per-channel divider: counter, active/shadow divisor and pending flag.
module pwm_tick_lane #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 389
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_i,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_act, div_act_nxt;
    logic [CNT_W-1:0] div_sh, div_sh_nxt;
    logic             pend, pend_nxt;
    logic             tick, tick_nxt;
    logic             apply;

    // Next-state: sync beats enable-low beats normal counting; the write path is
    // evaluated separately so a coincident boundary still applies the old shadow.
    always_comb begin
        cnt_nxt     = cnt;
        div_act_nxt = div_act;
        div_sh_nxt  = div_sh;
        pend_nxt    = pend;
        tick_nxt    = 1'b0;
        apply       = 1'b0;

        if (sync_i || !en) begin
            cnt_nxt = '0;
            apply   = 1'b1;
        end else if (cnt >= div_act) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            apply    = 1'b1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        // Only a pending shadow is moved; the apply clears the flag.
        if (apply && pend) begin
            div_act_nxt = div_sh;
            pend_nxt    = 1'b0;
        end

        // A write always wins the flag: the new value waits for the next boundary.
        if (wr_hit) begin
            div_sh_nxt = wr_div;
            pend_nxt   = 1'b1;
        end
    end

    // Channel state register with asynchronous reset to the default divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            div_sh  <= DIV_RST;
            pend    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_act <= div_act_nxt;
            div_sh  <= div_sh_nxt;
            pend    <= pend_nxt;
            tick    <= tick_nxt;
        end
    end

    assign tick_o = tick;
    assign pend_o = pend;

endmodule

// Top: write-channel decode and an array of identical lanes.
module pwm_tick_gen_mc #(
    parameter  int CH          = 4,
    parameter  int CNT_W       = 32,
    parameter  int DEFAULT_DIV = 389,
    localparam int CH_W        = $clog2(CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    en,
    input  logic             sync_i,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [CH-1:0]    tick_o,
    output logic [CH-1:0]    pend_o
);

    logic [CH-1:0] wr_hit;

    // Out-of-range channel numbers match no lane, so such writes are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        pwm_tick_lane #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (en[g]),
            .sync_i(sync_i),
            .wr_hit(wr_hit[g]),
            .wr_div(wr_div),
            .tick_o(tick_o[g]),
            .pend_o(pend_o[g])
        );
    end

endmodule
